// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter toward the PC. Bytes written by the design are buffered
//   in a small synchronous FIFO and serialised as 8N1 frames (start bit,
//   8 data bits LSB first, stop bit) on miso. Frames are sent back-to-back
//   while the FIFO holds data.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   wr_en     in   1      write request for wr_data
//   wr_data   in   8      byte to transmit
//   full      out  1      FIFO holds DEPTH entries (registered)
//   count     out  AW+1   FIFO occupancy 0..DEPTH (registered)
//   overflow  out  1      one-cycle pulse: write attempted while full, byte dropped
//   busy      out  1      frame in progress or FIFO not empty
//   miso      out  1      serial line to PC, idle high (registered)
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int DEPTH        = 16,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy,
  output logic          miso
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            miso_q, miso_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            full_q;
  logic            ovf_q;
  logic [7:0]      mem [DEPTH];
  logic            push, pop, bit_end;

  // full is the registered flag, so a write coinciding with a pop while full
  // is still refused.
  assign push    = wr_en & ~full_q;
  assign bit_end = (baud_q == BIT_LAST);

  // Transmit FSM: next state, baud/bit counters, shift register and the
  // next value of the miso register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    miso_d  = miso_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        miso_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
          miso_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          miso_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            miso_d  = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            miso_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next frame so there is no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
            miso_d  = 1'b0;
          end else begin
            state_d = IDLE;
            miso_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        miso_d  = 1'b1;
      end
    endcase
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      miso_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      miso_q   <= miso_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      ovf_q    <= wr_en & full_q;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage and shift register carry data only; they need no reset because
  // nothing reads them until a write/pop has loaded them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
    shift_q <= shift_d;
  end

  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) | (count_q != '0);
  assign miso     = miso_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: instance A uses 16 clk/bit, instance B derives its
// bit time from CLK_FREQ=500000, BAUD=9600 (52 clk/bit). Stimulus pushes
// expected bytes into per-instance queues; a UART monitor per instance
// decodes frames at mid-bit and compares against the queue head.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic [7:0] wr_data_a = '0, wr_data_b = '0;
  logic       full_a, overflow_a, busy_a, miso_a;
  logic       full_b, overflow_b, busy_b, miso_b;
  logic [4:0] count_a, count_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int starts_a[$];
  int starts_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .count(count_a), .overflow(overflow_a), .busy(busy_a), .miso(miso_a)
  );

  uart_tx_fifo #(.CLK_FREQ(500_000), .BAUD(9600)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .count(count_b), .overflow(overflow_b), .busy(busy_b), .miso(miso_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Called one half-cycle after the falling start edge; samples mid-bit.
  task automatic rx_frame(input int cpb, input bit sel, output logic [7:0] d,
                          output bit aborted, output bit framing_ok);
    logic s0, s9;
    aborted = 1'b0;
    d = '0;
    repeat (cpb / 2 - 1) begin @(negedge clk); if (!rst_n) aborted = 1'b1; end
    s0 = sel ? miso_b : miso_a;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) begin @(negedge clk); if (!rst_n) aborted = 1'b1; end
      d[i] = sel ? miso_b : miso_a;
    end
    repeat (cpb) begin @(negedge clk); if (!rst_n) aborted = 1'b1; end
    s9 = sel ? miso_b : miso_a;
    framing_ok = (s0 == 1'b0) && (s9 == 1'b1);
  endtask

  task automatic monitor(input bit sel, input int cpb);
    logic prev, cur;
    logic [7:0] d, e;
    bit ab, fok;
    string tag;
    tag = sel ? "b" : "a";
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = sel ? miso_b : miso_a;
      if (rst_n && prev && !cur) begin
        if (sel) starts_b.push_back(cyc); else starts_a.push_back(cyc);
        rx_frame(cpb, sel, d, ab, fok);
        if (!ab) begin
          chk({"framing_", tag}, 32'(fok), 32'd1);
          if ((sel ? qb.size() : qa.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte_%s actual=%0h required=none", tag, d);
          end else begin
            if (sel) e = qb.pop_front(); else e = qa.pop_front();
            chk({"rx_byte_", tag}, 32'(d), 32'(e));
          end
        end
        cur = sel ? miso_b : miso_a;
      end
      prev = cur;
    end
  endtask

  initial monitor(1'b0, 16);
  initial monitor(1'b1, 52);

  task automatic wr_a(input logic [7:0] d, input bit expect_tx);
    wr_en_a = 1'b1;
    wr_data_a = d;
    if (expect_tx) qa.push_back(d);
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] d);
    wr_en_b = 1'b1;
    wr_data_b = d;
    qb.push_back(d);
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input int budget, input string nm);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(sel ? busy_b : busy_a), 32'd0);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    bit bad;
    int n;
    repeat (3) @(negedge clk);
    // Reset state, both instances
    chk("rst_miso_a", 32'(miso_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_full_a", 32'(full_a), 32'd0);
    chk("rst_ovf_a", 32'(overflow_a), 32'd0);
    chk("rst_miso_b", 32'(miso_b), 32'd1);
    chk("rst_flags_b", {27'd0, full_b, overflow_b, busy_b, count_b == 5'd0, 1'b0}, 32'b00010);
    rst_n = 1'b1;

    // Idle for 100 cycles
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (miso_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 5'd0 || full_a !== 1'b0) bad = 1'b1;
    end
    chk("idle_100", 32'(bad), 32'd0);

    // Single byte 0xA5: miso falls one edge after the write
    wr_a(8'hA5, 1'b1);
    chk("lat_pre_miso", 32'(miso_a), 32'd1);
    chk("lat_pre_count", 32'(count_a), 32'd1);
    @(negedge clk);
    chk("lat_miso_low", 32'(miso_a), 32'd0);
    chk("pop_count", 32'(count_a), 32'd0);
    chk("busy_tx", 32'(busy_a), 32'd1);
    repeat (159) @(negedge clk);
    chk("busy_before_end", 32'(busy_a), 32'd1);
    @(negedge clk);
    chk("busy_clear_160", 32'(busy_a), 32'd0);

    // Burst: the first byte is popped one edge after it lands, so 17
    // consecutive writes leave 16 entries queued.
    @(negedge clk);
    for (int i = 0; i < 17; i++) wr_a(8'(i), 1'b1);
    chk("burst_count", 32'(count_a), 32'd16);
    chk("burst_full", 32'(full_a), 32'd1);
    wait_idle(1'b0, 17 * 160 + 50, "burst_drain");
    chk("burst_q_empty", qa.size(), 32'd0);
    n = starts_a.size();
    chk("burst_frames", 32'(n), 32'd18);
    if (n >= 17) begin
      for (int k = n - 16; k < n; k++) chk("b2b_period", 32'(starts_a[k] - starts_a[k-1]), 32'd160);
    end

    // Overflow while full
    @(negedge clk);
    for (int i = 0; i < 17; i++) wr_a(8'(8'h20 + i), 1'b1);
    wr_a(8'hEE, 1'b0);
    chk("ovf_pulse", 32'(overflow_a), 32'd1);
    chk("ovf_count", 32'(count_a), 32'd16);
    chk("ovf_full", 32'(full_a), 32'd1);
    @(negedge clk);
    chk("ovf_single", 32'(overflow_a), 32'd0);
    wait_idle(1'b0, 18 * 160 + 50, "ovf_drain");
    chk("ovf_q_empty", qa.size(), 32'd0);

    // Reset during data bit 3 of 0x3C, with 0x99 still queued
    @(negedge clk);
    wr_a(8'h3C, 1'b0);
    wr_a(8'h99, 1'b0);
    repeat (70) @(negedge clk);
    chk("pre_rst_count", 32'(count_a), 32'd1);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_miso", 32'(miso_a), 32'd1);
    chk("midrst_count", 32'(count_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_miso", 32'(miso_a), 32'd1);
    chk("post_rst_busy", 32'(busy_a), 32'd0);
    wr_a(8'h81, 1'b1);
    wait_idle(1'b0, 400, "post_rst_drain");
    chk("post_rst_q_empty", qa.size(), 32'd0);

    // Derived bit time (52 clk): two frames back-to-back, 0x55 then 0xC3
    @(negedge clk);
    wr_b(8'h55);
    wr_b(8'hC3);
    repeat (1039) @(negedge clk);
    chk("b_busy_before_end", 32'(busy_b), 32'd1);
    @(negedge clk);
    chk("b_busy_clear_1040", 32'(busy_b), 32'd0);
    chk("b_q_empty", qb.size(), 32'd0);
    chk("b_frames", starts_b.size(), 32'd2);
    if (starts_b.size() == 2) chk("b_frame_len", 32'(starts_b[1] - starts_b[0]), 32'd520);

    repeat (20) @(negedge clk);
    chk("final_qa_empty", qa.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
